// File: rtl/config_frame_loader.sv
// config_frame_loader
//   Frame-based configuration writer. Locks onto a sync word, parses a frame
//   header (col/frame), collects one 32-bit word per tile row into FrameData,
//   then pulses one FrameStrobe bit for a single cycle to load the tile
//   frame latches.
//
//   Optional: define CONFIG_FRAME_LOADER_CRC_EN to require a trailing check
//   word (XOR of header and all data words) before the strobe fires.
//
// Ports
//   CLK          configuration clock, rising edge
//   resetn       async active-low reset
//   WriteData    bitstream word
//   WriteStrobe  WriteData valid (always accepted)
//   FrameData    assembled frame, row r at [32r+31:32r]
//   FrameStrobe  one-hot latch pulse, bit = col*MaxFramesPerCol+frame
//   Active       high while synced (state != IDLE)
//   Error        sticky protocol error, cleared by the next sync word

// One row slot of the frame data register.
module frame_row_slot (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn)  q <= '0;
    else if (we)  q <= d;
endmodule

module config_frame_loader #(
  parameter int          NumberOfRows    = 16,
  parameter int          NumberOfCols    = 16,
  parameter int          MaxFramesPerCol = 20,
  parameter logic [31:0] SyncWord        = 32'hFAB0FAB1
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [31:0]                             WriteData,
  input  logic                                    WriteStrobe,
  output logic [32*NumberOfRows-1:0]              FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    Active,
  output logic                                    Error
);
  localparam int NumStrobes = NumberOfCols * MaxFramesPerCol;
  localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int IW = (NumStrobes > 1) ? $clog2(NumStrobes) : 1;

`ifdef CONFIG_FRAME_LOADER_CRC_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

  state_t state, next_state;

  logic [RW-1:0] row_cnt;
  logic [7:0]    col_q, frame_q;
  logic          hdr_load, row_wr, fire, set_err, clr_err;
  logic          hdr_ok, last_row;
  logic [IW-1:0]         strobe_idx;
  logic [NumStrobes-1:0] strobe_vec;

`ifdef CONFIG_FRAME_LOADER_CRC_EN
  logic [31:0] crc_q;
`endif

  assign hdr_ok   = WriteData[31]
                  && (32'(WriteData[15:8]) < NumberOfCols)
                  && (32'(WriteData[7:0])  < MaxFramesPerCol);
  assign last_row = (row_cnt == RW'(NumberOfRows - 1));
  assign Active   = (state != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= next_state;

  always_comb begin
    next_state = state;
    hdr_load   = 1'b0;
    row_wr     = 1'b0;
    fire       = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    if (WriteStrobe) begin
      case (state)
        IDLE: if (WriteData == SyncWord) begin
          next_state = HDR;
          clr_err    = 1'b1;
        end
        HDR: begin
          if (WriteData == '0)            next_state = IDLE;
          else if (WriteData == SyncWord) next_state = HDR;
          else if (hdr_ok) begin
            hdr_load   = 1'b1;
            next_state = DATA;
          end else begin
            set_err    = 1'b1;
            next_state = IDLE;
          end
        end
        DATA: begin
          // Sync word is plain data here; no mid-frame resync.
          row_wr = 1'b1;
          if (last_row) begin
`ifdef CONFIG_FRAME_LOADER_CRC_EN
            next_state = CHK;
`else
            fire       = 1'b1;
            next_state = HDR;
`endif
          end
        end
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        CHK: begin
          if (WriteData == crc_q) begin
            fire       = 1'b1;
            next_state = HDR;
          end else begin
            set_err    = 1'b1;
            next_state = IDLE;
          end
        end
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------- strobe decode ----------------
  assign strobe_idx = IW'(col_q) * IW'(MaxFramesPerCol) + IW'(frame_q);

  always_comb begin
    strobe_vec             = '0;
    strobe_vec[strobe_idx] = 1'b1;
  end

  // ---------------- control datapath ----------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_cnt     <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      Error       <= 1'b0;
      FrameStrobe <= '0;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      // Registered decode gives the one-cycle strobe latency and self-clear.
      FrameStrobe <= fire ? strobe_vec : '0;
      if (clr_err)      Error <= 1'b0;
      else if (set_err) Error <= 1'b1;
      if (hdr_load) begin
        col_q   <= WriteData[15:8];
        frame_q <= WriteData[7:0];
        row_cnt <= '0;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        crc_q   <= WriteData;
`endif
      end
      if (row_wr) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        crc_q   <= crc_q ^ WriteData;
`endif
      end
    end
  end

  // ---------------- frame data rows ----------------
  genvar r;
  generate
    for (r = 0; r < NumberOfRows; r++) begin : g_row
      frame_row_slot u_slot (
        .CLK    (CLK),
        .resetn (resetn),
        .we     (row_wr && (row_cnt == RW'(r))),
        .d      (WriteData),
        .q      (FrameData[32*r +: 32])
      );
    end
  endgenerate

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: sync/header/data flow, strobe
// timing, out-of-range header error, back-to-back frames, desync and
// mid-frame reset. Check-word frames when CONFIG_FRAME_LOADER_CRC_EN is set.
module tb_config_frame_loader;
  localparam int          ROWS = 16;
  localparam int          NS   = 16 * 20;
  localparam logic [31:0] SYNC = 32'hFAB0FAB1;

  logic                 CLK = 1'b0;
  logic                 resetn = 1'b0;
  logic                 WriteStrobe = 1'b0;
  logic [31:0]          WriteData = '0;
  logic [ROWS*32-1:0]   FrameData;
  logic [NS-1:0]        FrameStrobe;
  logic                 Active, Error;

  int n_chk = 0, n_pass = 0, n_strobe = 0, n_multi = 0;

  always #5 CLK = ~CLK;

  config_frame_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Active      (Active),
    .Error       (Error)
  );

  // Strobe pulse counter (one count per high cycle).
  always @(negedge CLK)
    if (|FrameStrobe) begin
      n_strobe++;
      if ($countones(FrameStrobe) != 1) n_multi++;
    end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NS-1:0] oh(input int i);
    logic [NS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [511:0] fexp(input logic [31:0] base);
    logic [511:0] v;
    for (int r = 0; r < ROWS; r++) v[r*32 +: 32] = base + 32'(r);
    return v;
  endfunction

  function automatic logic [31:0] xsum(input logic [31:0] hdr, input logic [31:0] base);
    logic [31:0] x;
    x = hdr;
    for (int i = 0; i < ROWS; i++) x = x ^ (base + 32'(i));
    return x;
  endfunction

  task automatic wr(input logic [31:0] w);
    @(negedge CLK);
    WriteData   = w;
    WriteStrobe = 1'b1;
  endtask

  task automatic idle();
    @(negedge CLK);
    WriteStrobe = 1'b0;
  endtask

  // Data words (plus check word in CRC builds) following an accepted header.
  task automatic tail(input logic [31:0] hdr, input logic [31:0] base);
    for (int i = 0; i < ROWS; i++) wr(base + 32'(i));
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    wr(xsum(hdr, base));
`else
    if (hdr == 32'hFFFF_FFFF) wr(xsum(hdr, base)); // never taken; keeps args used
`endif
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_framedata", FrameData, '0);
    chk("rst_strobe",    FrameStrobe, '0);
    chk("rst_active",    Active, 0);
    chk("rst_error",     Error, 0);
    @(negedge CLK);
    resetn = 1'b1;

    // Test 1: junk, sync, frame col 2 frame 5 -> bit 45
    wr(32'h12345678); idle();
    chk("junk_active", Active, 0);
    chk("junk_strobe_cnt", n_strobe, 0);
    wr(SYNC); idle();
    chk("sync_active", Active, 1);
    wr(32'h80000205);
    tail(32'h80000205, 32'h100);
    idle();
    chk("f1_strobe", FrameStrobe, oh(45));
    idle();
    chk("f1_strobe_clear", FrameStrobe, '0);
    chk("f1_row0",  FrameData[31:0], 32'h100);
    chk("f1_row15", FrameData[511:480], 32'h10F);
    chk("f1_data",  FrameData, fexp(32'h100));
    chk("f1_pulses", n_strobe, 1);

    // Test 2: resync is harmless, col 16 is out of range
    wr(SYNC);
    wr(32'h80001000); idle();
    chk("oor_error",  Error, 1);
    chk("oor_active", Active, 0);
    chk("oor_strobe_cnt", n_strobe, 1);
    wr(SYNC); idle();
    chk("oor_err_clr", Error, 0);
    chk("oor_resync_active", Active, 1);

    // Test 3: back-to-back, header of frame 2 in strobe cycle of frame 1
    wr(32'h80000000);
    tail(32'h80000000, 32'h200);
    wr(32'h80000F13);
    chk("b2b_strobe0", FrameStrobe, oh(0));
    tail(32'h80000F13, 32'h300);
    idle();
    chk("b2b_strobe319", FrameStrobe, oh(319));
    chk("b2b_data", FrameData, fexp(32'h300));
    idle();
    chk("b2b_pulses", n_strobe, 3);

    // Test 5: desync drops Active one cycle later; header then ignored
    wr(32'h0);
    chk("desync_active_before", Active, 1);
    idle();
    chk("desync_active", Active, 0);
    wr(32'h80000205); idle(); idle();
    chk("desync_hdr_err", Error, 0);
    chk("desync_hdr_active", Active, 0);
    chk("desync_pulses", n_strobe, 3);

    // Test 4: reset mid-frame
    wr(SYNC);
    wr(32'h80000205);
    for (int i = 0; i < 7; i++) wr(32'h400 + 32'(i));
    @(negedge CLK);
    WriteStrobe = 1'b0;
    resetn      = 1'b0;
    #1;
    chk("mrst_framedata", FrameData, '0);
    chk("mrst_strobe",    FrameStrobe, '0);
    chk("mrst_active",    Active, 0);
    chk("mrst_error",     Error, 0);
    @(negedge CLK);
    resetn = 1'b1;
    for (int i = 0; i < ROWS; i++) wr(32'h500 + 32'(i));
    idle(); idle();
    chk("mrst_no_strobe", n_strobe, 3);
    chk("mrst_active_after", Active, 0);
    chk("mrst_data_kept0", FrameData, '0);

`ifdef CONFIG_FRAME_LOADER_CRC_EN
    // Check-word frames: good then single bit flipped
    wr(SYNC);
    wr(32'h80000103);
    for (int i = 0; i < ROWS; i++) wr(32'h600 + 32'(i));
    wr(xsum(32'h80000103, 32'h600));
    idle();
    chk("crc_good_strobe", FrameStrobe, oh(23));
    idle();
    wr(32'h80000103);
    for (int i = 0; i < ROWS; i++) wr(32'h600 + 32'(i));
    wr(xsum(32'h80000103, 32'h600) ^ 32'h1);
    idle();
    chk("crc_bad_strobe", FrameStrobe, '0);
    chk("crc_bad_error",  Error, 1);
    chk("crc_bad_active", Active, 0);
    idle();
    chk("crc_pulses", n_strobe, 4);
`endif

    chk("never_multi_hot", n_multi, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/config_frame_loader.md
Name: config_frame_loader

Overview:
- Word-stream configuration writer that drives the frame-based configuration interface read by the fabric tiles.
- Tile BELs and switch matrices take their ConfigBits from frame latches. This block produces the FrameData bus and the one-hot FrameStrobe pulses that load those latches.
- It sits between the bitstream source (e.g. a UART or SPI word assembler) and the fabric.
- It locks onto a sync word, parses frame headers, assembles one data word per tile row, then pulses exactly one column/frame strobe.

Parameters:
- NumberOfRows, 16, tile rows; one 32-bit data word per row per frame.
- NumberOfCols, 16, tile columns; valid column index range 0..NumberOfCols-1.
- MaxFramesPerCol, 20, frames per column; valid frame index range 0..MaxFramesPerCol-1.
- SyncWord, 32'hFAB0FAB1, word that enters the synced state.

Ports:
- CLK  in  1  configuration clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- WriteData  in  32  bitstream word.
- WriteStrobe  in  1  WriteData valid this cycle. Always accepted; no backpressure.
- FrameData  out  32*NumberOfRows  assembled frame; row r occupies bits [32r+31:32r].
- FrameStrobe  out  NumberOfCols*MaxFramesPerCol  one-hot, single-cycle latch pulse; bit index = col*MaxFramesPerCol+frame.
- Active  out  1  high while synced (any state other than IDLE).
- Error  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, resetn=0): state=IDLE, FrameData=0, FrameStrobe=0, Active=0, Error=0, row counter=0, stored col/frame=0.
- Cycles without WriteStrobe change no state. FrameStrobe still self-clears.
- IDLE:
  - Every word is ignored except SyncWord.
  - SyncWord -> HDR, and clears Error in the same edge.
- HDR, classification of an accepted word:
  - WriteData==0 (desync) -> IDLE.
  - WriteData==SyncWord -> stay in HDR (resync, harmless).
  - WriteData[31]==1 with col=WriteData[15:8] < NumberOfCols and frame=WriteData[7:0] < MaxFramesPerCol -> store col/frame, row counter=0, -> DATA.
  - Any other word (bit31=0 nonzero, or out-of-range col/frame) -> Error=1, -> IDLE, no strobe.
- DATA:
  - Each accepted word is written to FrameData row slot [row counter], then the counter increments.
  - On the word with row counter==NumberOfRows-1:
    - next state = HDR;
    - FrameStrobe[col*MaxFramesPerCol+frame] goes high in the following cycle for exactly 1 cycle.
- FrameStrobe timing and data holding:
  - Latency is 1 cycle from acceptance of the last data word to the strobe.
  - FrameData is stable during the strobe cycle, because the earliest next write to FrameData is a DATA word after a header, at least 2 cycles later.
  - FrameData holds its value between frames; it is not cleared.
- Back-to-back operation: a header may be accepted in the strobe cycle. Zero idle cycles are needed between frames.
- Sync word in DATA: treated as ordinary data; no resync mid-frame.
- No timeout: an incomplete frame waits indefinitely. resetn is the only abort.
- FrameStrobe is never multi-hot.
- Active = (state != IDLE).
- Reset mid-frame: everything returns to reset values immediately. A pending strobe is suppressed.

Optional Feature:
- Macro name: CONFIG_FRAME_LOADER_CRC_EN.
- With the macro defined:
  - After the NumberOfRows data words, one extra check word is expected: the XOR of the header and all data words of that frame.
  - State DATA -> CHK, then the check word is compared.
  - Match -> strobe 1 cycle later, -> HDR.
  - Mismatch -> Error=1, no strobe, -> IDLE.
  - Strobe latency is measured from the check word.
- Without the macro: no CHK state; the strobe follows the last data word as described in Behaviour.

Test Plan:
- Stimulus: 0x12345678, 0xFAB0FAB1, header 0x80000205, data words 0x100..0x10F.
  - Active=1 after the sync word.
  - FrameStrobe bit 45 high for exactly 1 cycle, one cycle after word 0x10F.
  - FrameData[31:0]=0x100 and FrameData[511:480]=0x10F.
  - No strobe or state change caused by 0x12345678.
- Stimulus: sync, header 0x80001000 (col 16, out of range).
  - Error=1, Active=0, FrameStrobe stays 0.
  - A following SyncWord clears Error.
- Stimulus: two frames back-to-back with WriteStrobe continuous (col 0 frame 0, then col 15 frame 19); header of frame 2 lands in the strobe cycle of frame 1.
  - Strobe bit 0 then bit 319 (15*20+19); no lost words.
- Stimulus: sync, header, 7 data words, then resetn pulse low.
  - All outputs 0 immediately.
  - A subsequent 16 data words without sync produce no strobe.
- Stimulus: sync, one full frame, then 0x00000000.
  - Active drops the cycle after the desync word.
  - A further header word is ignored (no Error, no strobe).
- With CRC_EN: a frame with correct XOR check word -> strobe; the same frame with 1 check bit flipped -> Error=1 and no strobe.
